// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional saturating performance counters are enabled with `define PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, main_free;

  // in_ready comes straight off the skid flop, so no combinational path from out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // Stage boundary: main/skid entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= accept;
        if (accept) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end else begin
          skid_ctrl <= '0;
        end
      end else if (accept) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (main_valid && !out_ready)
        stall_cnt <= sat_inc(stall_cnt);
      if (!main_valid && !flush)
        bubble_cnt <= sat_inc(bubble_cnt);
      if (flush && (main_valid || skid_valid))
        flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed, table-driven bench for pipe_stage_skid_reg (streaming, backpressure, flush, bubbles, reset).
// Counter checks compile in only when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 9;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [3:0]  stall2, bubble2, flush2;
  logic        in_ready2, out_valid2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [DATA_W-1:0] out_data2;
`endif

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Second instance, permanently stalled, to exercise counter saturation.
  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(1'b1), .in_ready(in_ready2), .in_ctrl(9'h1), .in_data(96'h1),
    .out_valid(out_valid2), .out_ready(1'b0), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .stall_cnt(stall2), .bubble_cnt(bubble2), .flush_cnt(flush2)
  );
`endif

  typedef struct {
    logic              iv;
    logic              ordy;
    logic              fl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              e_ov;
    logic              e_ir;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [CTRL_W-1:0] c,
                              logic [DATA_W-1:0] d, logic e_ov, logic e_ir,
                              logic [CTRL_W-1:0] e_c, logic [DATA_W-1:0] e_d);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = c; v.data = d;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_ctrl = e_c; v.e_data = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = iv; out_ready = ordy; flush = fl; in_ctrl = c; in_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_ctrl", out_ctrl, 0);
    chk("reset_out_data", out_data, 0);
    rst = 1'b0;

    // Streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 1, 0, CTRL_W'(k), DATA_W'(k), 1, 1, CTRL_W'(k), DATA_W'(k)));
    // Bubbles: ctrl zeroed, data held
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 0, 9'h0, 96'h0, 0, 1, 9'h0, 96'h8));
    // Backpressure: A into main, B into skid, blocked C not accepted, then drain in order
    vecs.push_back(mk(1, 0, 0, 9'h11, 96'h11, 1, 1, 9'h11, 96'h11));
    vecs.push_back(mk(1, 0, 0, 9'h22, 96'h22, 1, 0, 9'h11, 96'h11));
    vecs.push_back(mk(1, 0, 0, 9'h55, 96'h55, 1, 0, 9'h11, 96'h11));
    vecs.push_back(mk(0, 1, 0, 9'h0,  96'h0,  1, 1, 9'h22, 96'h22));
    vecs.push_back(mk(0, 1, 0, 9'h0,  96'h0,  0, 1, 9'h0,  96'h22));
    // Flush with both entries full and C offered: C discarded, A's data held
    vecs.push_back(mk(1, 0, 0, 9'h11, 96'h11, 1, 1, 9'h11, 96'h11));
    vecs.push_back(mk(1, 0, 0, 9'h22, 96'h22, 1, 0, 9'h11, 96'h11));
    vecs.push_back(mk(1, 1, 1, 9'h33, 96'h33, 0, 1, 9'h0,  96'h11));
    vecs.push_back(mk(0, 1, 0, 9'h0,  96'h0,  0, 1, 9'h0,  96'h11));
    // Accept + issue on full main with empty skid goes straight to main
    vecs.push_back(mk(1, 0, 0, 9'h44, 96'h44, 1, 1, 9'h44, 96'h44));
    vecs.push_back(mk(1, 1, 0, 9'h45, 96'h45, 1, 1, 9'h45, 96'h45));
    vecs.push_back(mk(0, 1, 0, 9'h0,  96'h0,  0, 1, 9'h0,  96'h45));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data);
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl, vecs[i].e_ctrl);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
    end

    // Asynchronous reset mid-cycle with both entries full
    drive(1, 0, 0, 9'h66, 96'h66); step();
    drive(1, 0, 0, 9'h77, 96'h77); step();
    chk("prefill_in_ready", in_ready, 0);
    chk("prefill_out_ctrl", out_ctrl, 9'h66);
    drive(1, 0, 0, 9'h1AB, 96'h1AB);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_ctrl", out_ctrl, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 1);
    drive(0, 1, 0, 9'h0, 96'h0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

`ifdef PIPE_STAGE_PERF_CNT_EN
    rst = 1'b1;
    drive(1, 0, 0, 9'h11, 96'h11);
    #2 rst = 1'b0;
    step();                                          // bubble 1, A into main
    drive(0, 0, 0, 9'h0, 96'h0);
    for (int k = 0; k < 4; k++) step();              // stalls 1..4
    drive(0, 1, 1, 9'h0, 96'h0); step();             // flush 1
    drive(1, 0, 0, 9'h22, 96'h22); step();           // bubble 2, B into main
    drive(0, 1, 1, 9'h0, 96'h0); step();             // flush 2
    drive(0, 1, 0, 9'h0, 96'h0); step();             // bubble 3
    chk("stall_cnt", stall_cnt, 4);
    chk("flush_cnt", flush_cnt, 2);
    chk("bubble_cnt", bubble_cnt, 3);
    for (int k = 0; k < 20; k++) step();
    chk("stall_cnt_saturated", stall2, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
